// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch/PC front end of the single-cycle core.
// Latency: n/a (types, constants and a pure helper only).
// Backpressure: n/a.
package cpu_types_pkg;

    // Next-PC source selected by the control unit for the instruction in decode.
    typedef enum logic [1:0] {
        PC4    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2,
        JR     = 2'd3
    } pc_src_t;

    // Instruction sequencing states of fetch_sequencer.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        MEM    = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    // Sequential instruction stride in bytes.
    localparam logic [31:0] PC_STEP = 32'd4;

    // Branch displacement: sign-extended word offset converted to a byte offset.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Next-PC selection: sequential, conditional branch, jump or jump-register.
// Latency: purely combinational, pc_in is valid in the same cycle as its inputs.
// Backpressure: none; the consumer samples pc_in only when it is enabled.
module next_pc_calc
    import cpu_types_pkg::*;
(
    input  logic [31:0] pc_out,
    input  pc_src_t     pc_src,
    input  logic        branch_taken,
    input  logic [31:0] instr_out,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_in
);

    logic [31:0] pc4;
    logic [31:0] br_tgt;
    logic [31:0] jmp_tgt;
    logic        unused_opcode;

    // The opcode field plays no part in target formation.
    assign unused_opcode = ^instr_out[31:26];

    // Both adders wrap modulo 2^32, which is the architectural behaviour.
    assign pc4     = pc_out + PC_STEP;
    assign br_tgt  = pc4 + branch_offset(instr_out[15:0]);
    assign jmp_tgt = {pc4[31:28], instr_out[25:0], 2'b00};

    // Select the target; JR passes rs straight through, even if unaligned.
    always_comb begin
        pc_in = pc4;
        unique case (pc_src)
            PC4:     pc_in = pc4;
            BRANCH:  pc_in = branch_taken ? br_tgt : pc4;
            JUMP:    pc_in = jmp_tgt;
            JR:      pc_in = rs_data;
            default: pc_in = pc4;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Sequences each instruction through fetch, execute and optional data access; owns halt latch.
// Latency: 1 + ihit wait + 1 cycles per plain instruction; loads/stores add dhit wait + 1.
// Backpressure: waits indefinitely on ihit/dhit unless the MEM_TIMEOUT watchdog is enabled.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter int MEM_TIMEOUT = 0,
    parameter int TO_W        = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] pc_out,
    input  logic        ihit,
    input  logic [31:0] imemload,
    input  logic        dhit,
    input  logic        dmem_read,
    input  logic        dmem_write,
    input  logic        halt,
    input  logic [1:0]  pc_src,
    input  logic        branch_taken,
    input  logic [31:0] rs_data,
    output logic [31:0] instr_out,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic [31:0] pc_in,
    output logic        pcWEN,
    output logic        retire,
    output logic        halt_out,
    output logic        mem_err
);

    localparam bit            WD_EN    = (MEM_TIMEOUT > 0);
    localparam logic [TO_W-1:0] WD_LIMIT = TO_W'(MEM_TIMEOUT);

    fetch_state_t    state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic            halt_q,  halt_d;
    logic            err_q,   err_d;
    logic [TO_W-1:0] wd_q,    wd_d;

    // Set when the current cycle waits on a memory hit that did not arrive.
    logic            wd_miss;
    logic [TO_W-1:0] wd_inc;

    assign wd_inc = wd_q + 1'b1;

    // Target computation only depends on the held instruction, so it is stable
    // throughout EXEC and MEM regardless of how long the data access takes.
    next_pc_calc u_next_pc (
        .pc_out       (pc_out),
        .pc_src       (pc_src_t'(pc_src)),
        .branch_taken (branch_taken),
        .instr_out    (instr_q),
        .rs_data      (rs_data),
        .pc_in        (pc_in)
    );

    // Next-state, memory requests and commit strobes.
    always_comb begin
        state_d  = state_q;
        instr_d  = instr_q;
        halt_d   = halt_q;
        err_d    = err_q;
        wd_d     = '0;
        wd_miss  = 1'b0;
        imemREN  = 1'b0;
        imemaddr = pc_out;
        dmemREN  = 1'b0;
        dmemWEN  = 1'b0;
        pcWEN    = 1'b0;
        retire   = 1'b0;

        unique case (state_q)
            FETCH: begin
                imemREN = 1'b1;
                if (ihit) begin
                    instr_d = imemload;
                    state_d = EXEC;
                end else begin
                    wd_miss = 1'b1;
                end
            end
            EXEC: begin
                // Halt outranks a memory op: a HALT never touches data memory.
                if (halt) begin
                    halt_d  = 1'b1;
                    state_d = HALTED;
                end else if (dmem_read || dmem_write) begin
                    state_d = MEM;
                end else begin
                    pcWEN   = 1'b1;
                    retire  = 1'b1;
                    state_d = FETCH;
                end
            end
            MEM: begin
                dmemREN = dmem_read;
                dmemWEN = dmem_write;
                if (dhit) begin
                    pcWEN   = 1'b1;
                    retire  = 1'b1;
                    state_d = FETCH;
                end else begin
                    wd_miss = 1'b1;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // The count includes the current missed cycle, so the fault fires in the
        // MEM_TIMEOUT-th consecutive miss; a hit in that cycle never reaches here.
        if (WD_EN && wd_miss) begin
            wd_d = wd_inc;
            if (wd_inc == WD_LIMIT) begin
                state_d = HALTED;
                err_d   = 1'b1;
                halt_d  = 1'b1;
                wd_d    = '0;
            end
        end
    end

    // State, latched instruction, sticky flags and watchdog count.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            instr_q <= '0;
            halt_q  <= 1'b0;
            err_q   <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            halt_q  <= halt_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
        end
    end

    assign instr_out = instr_q;
    assign halt_out  = halt_q;
    assign mem_err   = err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: vector table plus hand-written corner sequences.
// Latency: expected next-PC values queued at stimulus time, popped on each pcWEN.
// Backpressure: ihit/dhit delays are driven per vector.
module tb_fetch_sequencer;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pc_out;
    logic        ihit;
    logic [31:0] imemload;
    logic        dhit;
    logic        dmem_read;
    logic        dmem_write;
    logic        halt;
    logic [1:0]  pc_src;
    logic        branch_taken;
    logic [31:0] rs_data;
    logic [31:0] instr_out;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        dmemREN;
    logic        dmemWEN;
    logic [31:0] pc_in;
    logic        pcWEN;
    logic        retire;
    logic        halt_out;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        pc_src_t     src;
        logic        taken;
        logic [31:0] rs;
        logic        rd;
        logic        wr;
        int          iwait;
        int          dwait;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[11];

    fetch_sequencer #(.MEM_TIMEOUT(4), .TO_W(16)) dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .pc_out       (pc_out),
        .ihit         (ihit),
        .imemload     (imemload),
        .dhit         (dhit),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .halt         (halt),
        .pc_src       (pc_src),
        .branch_taken (branch_taken),
        .rs_data      (rs_data),
        .instr_out    (instr_out),
        .imemREN      (imemREN),
        .imemaddr     (imemaddr),
        .dmemREN      (dmemREN),
        .dmemWEN      (dmemWEN),
        .pc_in        (pc_in),
        .pcWEN        (pcWEN),
        .retire       (retire),
        .halt_out     (halt_out),
        .mem_err      (mem_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard: every pcWEN must match the oldest queued target and carry retire.
    always @(negedge CLK) begin
        if (nRST === 1'b1) begin
            if (pcWEN === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("pcwen_unexpected", 32'(pcWEN), 32'd0);
                end else begin
                    exp_pc = exp_q.pop_front();
                    chk("pc_in", pc_in, exp_pc);
                end
                chk("retire_with_pcwen", 32'(retire), 32'd1);
            end else if (retire !== 1'b0) begin
                chk("retire_without_pcwen", 32'(retire), 32'd0);
            end
        end
    end

    task automatic run_vec(input int idx, input vec_t v);
        int rdc;
        int wrc;
        int pwc;
        rdc = 0;
        wrc = 0;
        pc_out       = v.pc;
        pc_src       = v.src;
        branch_taken = v.taken;
        rs_data      = v.rs;
        dmem_read    = v.rd;
        dmem_write   = v.wr;
        halt         = 1'b0;
        ihit         = 1'b0;
        dhit         = 1'b0;
        imemload     = 32'hDEAD_BEEF;
        exp_q.push_back(v.exp_pc);
        for (int k = 0; k < v.iwait; k++) begin
            @(negedge CLK);
            chk($sformatf("v%0d_fetch_wait_imemREN", idx), 32'(imemREN), 32'd1);
            step();
        end
        ihit     = 1'b1;
        imemload = v.instr;
        @(negedge CLK);
        chk($sformatf("v%0d_imemaddr", idx), imemaddr, v.pc);
        chk($sformatf("v%0d_fetch_imemREN", idx), 32'(imemREN), 32'd1);
        pwc = int'(pcWEN);
        step();
        ihit     = 1'b0;
        imemload = 32'hDEAD_BEEF;
        @(negedge CLK);
        chk($sformatf("v%0d_exec_reqs", idx), 32'({imemREN, dmemREN, dmemWEN}), 32'd0);
        chk($sformatf("v%0d_instr_out", idx), instr_out, v.instr);
        pwc += int'(pcWEN);
        step();
        if (v.rd || v.wr) begin
            for (int k = 0; k < v.dwait; k++) begin
                dhit = (k == v.dwait - 1);
                @(negedge CLK);
                rdc += int'(dmemREN);
                wrc += int'(dmemWEN);
                pwc += int'(pcWEN);
                chk($sformatf("v%0d_mem_imemREN", idx), 32'(imemREN), 32'd0);
                if (k != v.dwait - 1)
                    chk($sformatf("v%0d_mem_early_pcWEN", idx), 32'(pcWEN), 32'd0);
                step();
            end
            dhit = 1'b0;
        end
        chk($sformatf("v%0d_dmemREN_cycles", idx), 32'(rdc), 32'(v.rd ? v.dwait : 0));
        chk($sformatf("v%0d_dmemWEN_cycles", idx), 32'(wrc), 32'(v.wr ? v.dwait : 0));
        chk($sformatf("v%0d_pcWEN_count", idx), 32'(pwc), 32'd1);
    endtask

    // Global bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        //            pc            instr         src     tk    rs            rd    wr    iw dw exp_pc
        vecs[0]  = '{32'h0000_0000, 32'h2001_0005, PC4,    1'b0, 32'h0,        1'b0, 1'b0, 2, 0, 32'h0000_0004};
        vecs[1]  = '{32'h0000_0040, 32'h1000_FFFE, BRANCH, 1'b1, 32'h0,        1'b0, 1'b0, 0, 0, 32'h0000_003C};
        vecs[2]  = '{32'h0000_0040, 32'h1000_FFFE, BRANCH, 1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 32'h0000_0044};
        vecs[3]  = '{32'h0000_0010, 32'h8C01_0000, PC4,    1'b0, 32'h0,        1'b1, 1'b0, 1, 3, 32'h0000_0014};
        vecs[4]  = '{32'hF000_0000, 32'h0800_0100, JUMP,   1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 32'hF000_0400};
        vecs[5]  = '{32'h0000_0100, 32'h0000_0008, JR,     1'b0, 32'h0000_1234, 1'b0, 1'b0, 0, 0, 32'h0000_1234};
        vecs[6]  = '{32'h0000_0100, 32'h0000_0008, JR,     1'b1, 32'h0000_1235, 1'b0, 1'b0, 1, 0, 32'h0000_1235};
        vecs[7]  = '{32'h0000_0020, 32'hAC01_0000, PC4,    1'b0, 32'h0,        1'b0, 1'b1, 3, 1, 32'h0000_0024};
        vecs[8]  = '{32'hFFFF_FFF0, 32'h1000_0008, BRANCH, 1'b1, 32'h0,        1'b0, 1'b0, 0, 0, 32'h0000_0014};
        vecs[9]  = '{32'hFFFF_FFFC, 32'h2001_0001, PC4,    1'b1, 32'h0,        1'b0, 1'b0, 0, 0, 32'h0000_0000};
        vecs[10] = '{32'h0000_0080, 32'hAC02_0004, PC4,    1'b0, 32'h0,        1'b0, 1'b1, 2, 3, 32'h0000_0084};

        nRST = 1'b0; pc_out = 32'h0000_ABC0; ihit = 1'b0; imemload = 32'h0;
        dhit = 1'b0; dmem_read = 1'b0; dmem_write = 1'b1; halt = 1'b0;
        pc_src = PC4; branch_taken = 1'b0; rs_data = 32'h0;

        // Reset state and outputs while reset is held.
        repeat (2) @(negedge CLK);
        chk("rst_imemREN",   32'(imemREN),   32'd1);
        chk("rst_imemaddr",  imemaddr,       32'h0000_ABC0);
        chk("rst_dmem_reqs", 32'({dmemREN, dmemWEN}), 32'd0);
        chk("rst_pcWEN",     32'(pcWEN),     32'd0);
        chk("rst_retire",    32'(retire),    32'd0);
        chk("rst_instr_out", instr_out,      32'd0);
        chk("rst_halt_out",  32'(halt_out),  32'd0);
        chk("rst_mem_err",   32'(mem_err),   32'd0);
        step();
        nRST = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(i, vecs[i]);
        chk("no_fault_after_vectors", 32'(mem_err), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a data access abandons the request.
        pc_out = 32'h0000_0300; dmem_read = 1'b1; dmem_write = 1'b0; halt = 1'b0;
        ihit = 1'b1; imemload = 32'h8C03_0000;
        step();
        ihit = 1'b0;
        step();
        @(negedge CLK);
        chk("midmem_dmemREN", 32'(dmemREN), 32'd1);
        nRST = 1'b0;
        #1;
        chk("midrst_dmemREN", 32'(dmemREN), 32'd0);
        chk("midrst_imemREN", 32'(imemREN), 32'd1);
        chk("midrst_instr",   instr_out,    32'd0);
        step();
        nRST = 1'b1;
        dmem_read = 1'b0;

        // HALT with a simultaneous store request: no store, sticky halt.
        pc_out = 32'h0000_0050; halt = 1'b1; dmem_write = 1'b1;
        ihit = 1'b1; imemload = 32'hFFFF_FFFF;
        step();
        ihit = 1'b0;
        @(negedge CLK);
        chk("halt_exec_dmemWEN", 32'(dmemWEN), 32'd0);
        chk("halt_exec_pcWEN",   32'(pcWEN),   32'd0);
        step();
        for (int k = 0; k < 3; k++) begin
            ihit = 1'b1; imemload = 32'h1234_5678;
            @(negedge CLK);
            chk("halted_halt_out", 32'(halt_out), 32'd1);
            chk("halted_reqs", 32'({imemREN, dmemREN, dmemWEN, pcWEN}), 32'd0);
            step();
        end
        chk("halted_instr_held", instr_out, 32'hFFFF_FFFF);
        ihit = 1'b0;
        nRST = 1'b0;
        #1;
        chk("halt_rst_halt_out", 32'(halt_out), 32'd0);
        chk("halt_rst_imemREN",  32'(imemREN),  32'd1);
        step();
        nRST = 1'b1; halt = 1'b0; dmem_write = 1'b0;

        // Watchdog: ihit never arrives, fault after the fourth missed cycle.
        pc_out = 32'h0000_0200;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("wd_pending_mem_err", 32'(mem_err), 32'd0);
            step();
        end
        @(negedge CLK);
        chk("wd_mem_err",  32'(mem_err),  32'd1);
        chk("wd_halt_out", 32'(halt_out), 32'd1);
        chk("wd_imemREN",  32'(imemREN),  32'd0);
        nRST = 1'b0;
        #1;
        chk("wd_rst_mem_err", 32'(mem_err), 32'd0);
        step();
        nRST = 1'b1;
        step();

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
